// File: rtl/mem_pkg.sv
// Shared encodings for the data memory responder: access sizes and FSM states.
package mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Transaction FSM: accept in IDLE, count wait states in BUSY, present in RESP
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for a 32-bit little-endian word: merges store data into
// the addressed lanes and extracts/extends load data from them.
import mem_pkg::*;

module byte_lane_unit (
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store merge: overwrite only the lanes selected by size and low address bits
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]        = wdata_i[7:0];
            SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
            SZ_WORD: merged_o                                  = wdata_i;
            default: merged_o                                  = old_word_i;
        endcase
    end

    // Load extract: pick the addressed byte/half and sign- or zero-extend it
    always_comb begin
        byte_sel = old_word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = old_word_i[{addr_lo_i[1], 4'b0000} +: 16];
        rdata_o  = '0;
        case (size_i)
            SZ_BYTE: rdata_o = signed_i ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            SZ_HALF: rdata_o = signed_i ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            SZ_WORD: rdata_o = old_word_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response handshake,
// with a programmable number of wait states per access.
import mem_pkg::*;

module data_mem_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               we_q;
    logic [31:0]        addr_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [31:0]        wdata_q;
    logic [31:0]        pc_q;

    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    // Storage plus one "written since reset" bit per word; a word whose bit is
    // clear reads as zero, so reset clears the whole array in a single edge.
    logic [31:0]            mem_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] wvld_q;

    logic               accept;
    logic               access;
    logic               in_range;
    logic               misaligned;
    logic               err;
    logic               commit;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        old_word;
    logic [31:0]        merged_word;
    logic [31:0]        load_word;

    assign accept = req_valid && req_ready;
    assign access = (state_q == ST_BUSY) && (cnt_q == '0);

    // Error decode on the captured request
    always_comb begin
        in_range   = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
        misaligned = ((size_q == SZ_HALF) && addr_q[0]) ||
                     ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
        err        = (size_q == 2'b11) || misaligned || !in_range;
    end

    assign commit   = access && we_q && !err;
    assign idx      = addr_q[IDX_W+1:2];
    assign old_word = (in_range && wvld_q[idx]) ? mem_q[idx] : 32'h0;

    byte_lane_unit u_lanes (
        .old_word_i (old_word),
        .wdata_i    (wdata_q),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .signed_i   (signed_q),
        .merged_o   (merged_word),
        .rdata_o    (load_word)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid)   state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready)   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags are pure functions of the state
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
    end

    // Wait-state counter next value: load on accept, count down while busy
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = CNT_LOAD;
        end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Wait-state counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Request capture: fields frozen from acceptance until the next request
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            pc_q     <= req_pc;
        end
    end

    // Response registers: loaded on the access edge, held through RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (access) begin
            rsp_rdata_q <= (err || we_q) ? 32'h0 : load_word;
            rsp_err_q   <= err;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Written-word tracking: reset invalidates everything, a store validates its word
    always_ff @(posedge clk) begin
        if (reset) begin
            wvld_q <= '0;
        end else if (commit) begin
            wvld_q[idx] <= 1'b1;
        end
    end

    // Array write of the merged word, with a store log line in simulation
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            mem_q[idx] <= merged_word;
`ifndef SYNTHESIS
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged_word);
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with default parameters
// (3072 words, 2 wait states).
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp;
    int n_bad;

    data_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction: wait for req_ready, present, count latency, consume response
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_pc     = req_pc + 32'd4;
        req_valid  = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) check_val("accept_timeout", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) check_val("rsp_timeout", {31'h0, rsp_valid}, 32'h1);
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata);
        logic [31:0] rd;
        logic        e;
        int          lat;
        do_req(1'b1, addr, size, 1'b0, wdata, rd, e, lat);
        check_val({tag, "_err"}, {31'h0, e}, 32'h0);
        check_val({tag, "_rdata"}, rd, 32'h0);
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        int          lat;
        do_req(1'b0, addr, size, sgn, 32'h0, rd, e, lat);
        check_val({tag, "_err"}, {31'h0, e}, 32'h0);
        check_val({tag, "_rdata"}, rd, exp);
    endtask

    task automatic bad_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] size);
        logic [31:0] rd;
        logic        e;
        int          lat;
        do_req(we, addr, size, 1'b1, 32'hFFFF_FFFF, rd, e, lat);
        check_val({tag, "_err"}, {31'h0, e}, 32'h1);
        check_val({tag, "_rdata"}, rd, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] held;
        logic        e;
        int          lat;
        int          seen;
        int          guard;

        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_wdata  = '0;
        req_pc     = 32'h0000_1000;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_val("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
        check_val("rst_req_ready", {31'h0, req_ready}, 32'h1);

        // Word store then load, with latency
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'h1234_5678, rd, e, lat);
        check_val("w_st_lat", 32'(lat), 32'd3);
        check_val("w_st_err", {31'h0, e}, 32'h0);
        do_req(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, rd, e, lat);
        check_val("w_ld_lat", 32'(lat), 32'd3);
        check_val("w_ld_rdata", rd, 32'h1234_5678);
        check_val("w_ld_err", {31'h0, e}, 32'h0);

        // Byte lanes
        store("b_init", 32'h20, 2'b10, 32'h0000_0000);
        store("b_st",   32'h22, 2'b00, 32'h0000_0080);
        load("b_word",  32'h20, 2'b10, 1'b0, 32'h0080_0000);
        load("b_sld",   32'h22, 2'b00, 1'b1, 32'hFFFF_FF80);
        load("b_uld",   32'h22, 2'b00, 1'b0, 32'h0000_0080);
        load("b_lane0", 32'h20, 2'b00, 1'b1, 32'h0000_0000);

        // Halfword
        store("h_init", 32'h24, 2'b10, 32'h1111_1111);
        store("h_st",   32'h26, 2'b01, 32'hAAAA_BEEF);
        load("h_word",  32'h24, 2'b10, 1'b0, 32'hBEEF_1111);
        load("h_sld",   32'h26, 2'b01, 1'b1, 32'hFFFF_BEEF);
        load("h_uld",   32'h26, 2'b01, 1'b0, 32'h0000_BEEF);
        load("h_low",   32'h24, 2'b01, 1'b1, 32'h0000_1111);

        // Errors, each leaving memory untouched
        bad_req("e_half",  1'b0, 32'h01, 2'b01);
        bad_req("e_word",  1'b1, 32'h02, 2'b10);
        load("e_word_rb",  32'h00, 2'b10, 1'b0, 32'h0000_0000);
        bad_req("e_size",  1'b1, 32'h10, 2'b11);
        load("e_size_rb",  32'h10, 2'b10, 1'b0, 32'h1234_5678);
        bad_req("e_range_ld", 1'b0, 32'h3000, 2'b10);
        bad_req("e_range_st", 1'b1, 32'h3000, 2'b10);
        store("last_st",   32'h2FFC, 2'b10, 32'hA5A5_5A5A);
        load("last_ld",    32'h2FFF, 2'b00, 1'b0, 32'h0000_00A5);

        // Backpressure: response held 5 cycles while a new request waits
        req_we = 1'b0; req_addr = 32'h24; req_size = 2'b10; req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'hCAFE_BABE;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        held = rsp_rdata;
        check_val("bp_rdata", held, 32'hBEEF_1111);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
            check_val("bp_hold_rdata", rsp_rdata, held);
            check_val("bp_hold_err",   {31'h0, rsp_err}, 32'h0);
            check_val("bp_hold_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val("bp_rel_valid", {31'h0, rsp_valid}, 32'h0);
        check_val("bp_rel_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("bp_accept", {31'h0, req_ready}, 32'h0);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("bp_lat", 32'(guard), 32'd3);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        load("bp_rb", 32'h50, 2'b10, 1'b0, 32'hCAFE_BABE);

        // Reset during a pending store
        req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("rs_busy", {31'h0, req_ready}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("rs_ready", {31'h0, req_ready}, 32'h1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check_val("rs_no_rsp", 32'(seen), 32'd0);
        load("rs_rb40", 32'h40, 2'b10, 1'b0, 32'h0000_0000);
        load("rs_rb10", 32'h10, 2'b10, 1'b0, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
